// File: rtl/micro_delay_timer.sv
// micro_delay_timer
//   One-shot / optional periodic microsecond delay timer driven by an external
//   free-running microsecond time base. A start request captures the current
//   time and a duration. While running, the timer compares the modular
//   difference (time_micro - start point) with the duration. On expiry it
//   emits a one-cycle done pulse.
//
//   Configuration macro: MICRO_DELAY_PERIODIC_EN
//     undefined (default): periodic is ignored, and every expiry returns to IDLE.
//     defined            : periodic=1 at start selects drift-free auto-reload.
//
// Ports
//   clk        : system clock
//   rst        : asynchronous, active-high reset
//   time_micro : free-running microsecond count, synchronous to clk (TW bits)
//   start      : one-cycle arm / re-arm request
//   duration   : delay in microseconds, sampled when start is accepted (DW bits)
//   abort      : cancels a running delay; wins over start in the same cycle
//   periodic   : auto-reload request, sampled with start
//   busy       : high while the timer is running
//   done       : one-cycle expiry pulse (registered)
//   elapsed    : microseconds since the current arm point (registered, DW bits)

module micro_delay_timer #(
  parameter int unsigned TW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [TW-1:0] time_micro,
  input  logic          start,
  input  logic [DW-1:0] duration,
  input  logic          abort,
  input  logic          periodic,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] elapsed
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e        state_q,   state_d;
  logic [TW-1:0] start_q,   start_d;
  logic [DW-1:0] dur_q,     dur_d;
  logic          per_q,     per_d;
  logic [DW-1:0] elapsed_q, elapsed_d;
  logic          done_q,    done_d;

  logic [TW-1:0] diff_c;
  logic          expire_c;

  // Modular distance from the arm point; makes time base wrap transparent.
  assign diff_c   = time_micro - start_q;

  // Compare at full time-base width so a long-running diff never aliases low.
  assign expire_c = (state_q == RUN) && (diff_c >= TW'(dur_q));

`ifndef MICRO_DELAY_PERIODIC_EN
  // periodic and per_q carry no function in this build.
  logic unused_c;
  assign unused_c = ^{periodic, per_q};
`endif

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      start_q   <= '0;
      dur_q     <= '0;
      per_q     <= 1'b0;
      elapsed_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      dur_q     <= dur_d;
      per_q     <= per_d;
      elapsed_q <= elapsed_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic. Priority: abort, then start, then expiry.
  always_comb begin
    state_d   = state_q;
    start_d   = start_q;
    dur_d     = dur_q;
    per_d     = per_q;
    elapsed_d = elapsed_q;
    done_d    = 1'b0;

    if (abort) begin
      // Cancels without a done pulse; elapsed keeps its last value.
      state_d = IDLE;
    end else if (start) begin
      // Arm or re-arm; a coincident expiry is swallowed.
      state_d   = RUN;
      start_d   = time_micro;
      dur_d     = duration;
      elapsed_d = '0;
`ifdef MICRO_DELAY_PERIODIC_EN
      per_d     = periodic;
`else
      per_d     = 1'b0;
`endif
    end else if (state_q == RUN) begin
      elapsed_d = diff_c[DW-1:0];
      if (expire_c) begin
        done_d = 1'b1;
`ifdef MICRO_DELAY_PERIODIC_EN
        // Reload from the previous deadline rather than "now" to avoid drift.
        if (per_q) begin
          start_d = start_q + TW'(dur_q);
        end else begin
          state_d = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = done_q;
  assign elapsed = elapsed_q;

endmodule

// File: tb/tb_micro_delay_timer.sv
// Directed self-checking bench for micro_delay_timer. One microsecond of
// time_micro is advanced per clock so expected latencies are easy to derive.
module tb_micro_delay_timer;

  logic        clk;
  logic        rst;
  logic [31:0] time_micro;
  logic        start;
  logic [31:0] duration;
  logic        abort;
  logic        periodic;
  logic        busy;
  logic        done;
  logic [31:0] elapsed;

  int compared   = 0;
  int mismatched = 0;

  micro_delay_timer #(.TW(32), .DW(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .time_micro (time_micro),
    .start      (start),
    .duration   (duration),
    .abort      (abort),
    .periodic   (periodic),
    .busy       (busy),
    .done       (done),
    .elapsed    (elapsed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: outputs then reflect the edge just taken; time advances by 1.
  task automatic tick();
    @(posedge clk);
    #1;
    time_micro = time_micro + 32'd1;
  endtask

  // Ticks until done is seen (bounded); n is the number of ticks taken.
  task automatic wait_done(input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (done !== 1'b1 && n < budget);
  endtask

  task automatic count_done(input int k, output int c);
    c = 0;
    for (int i = 0; i < k; i++) begin
      tick();
      if (done === 1'b1) c++;
    end
  endtask

  task automatic arm(input logic [31:0] t, input logic [31:0] d, input logic p);
    time_micro = t;
    duration   = d;
    periodic   = p;
    start      = 1'b1;
    tick();
    start    = 1'b0;
    periodic = 1'b0;
  endtask

  int n;
  int c;

  initial begin
    rst = 1'b1; time_micro = 32'd0; start = 1'b0; duration = 32'd0;
    abort = 1'b0; periodic = 1'b0;
    #12;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_elapsed", 64'(elapsed), 64'd0);
    rst = 1'b0;
    tick();

    // One-shot: start at 100 with 5 -> done after the edge that sees 105.
    arm(32'd100, 32'd5, 1'b0);
    check("oneshot_busy_after_start", 64'(busy), 64'd1);
    check("oneshot_done_after_start", 64'(done), 64'd0);
    wait_done(20, n);
    check("oneshot_latency", 64'(n), 64'd5);
    check("oneshot_busy_at_done", 64'(busy), 64'd0);
    check("oneshot_elapsed", 64'(elapsed), 64'd5);
    tick();
    check("oneshot_done_single", 64'(done), 64'd0);
    check("oneshot_elapsed_hold", 64'(elapsed), 64'd5);

    // Wrap-around of the time base.
    arm(32'hFFFF_FFFE, 32'd4, 1'b0);
    wait_done(20, n);
    check("wrap_latency", 64'(n), 64'd4);
    check("wrap_elapsed", 64'(elapsed), 64'd4);

    // Abort at elapsed=3 of 10.
    arm(32'd200, 32'd10, 1'b0);
    tick(); tick(); tick();
    check("abort_pre_elapsed", 64'(elapsed), 64'd3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_elapsed_hold", 64'(elapsed), 64'd3);
    count_done(12, c);
    check("abort_no_done", 64'(c), 64'd0);
    check("idle_elapsed_const", 64'(elapsed), 64'd3);

    // start+abort together in IDLE and in RUN both leave IDLE.
    start = 1'b1; abort = 1'b1; duration = 32'd4;
    tick();
    start = 1'b0; abort = 1'b0;
    check("startabort_idle_busy", 64'(busy), 64'd0);
    arm(32'd250, 32'd6, 1'b0);
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("startabort_run_busy", 64'(busy), 64'd0);
    count_done(10, c);
    check("startabort_no_done", 64'(c), 64'd0);

    // Retrigger: 10 at t=0, again at t=6 -> done only after t=16.
    arm(32'd0, 32'd10, 1'b0);
    tick(); tick(); tick(); tick(); tick();
    check("retrig_busy_mid", 64'(busy), 64'd1);
    check("retrig_time", 64'(time_micro), 64'd6);
    duration = 32'd10; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(30, n);
    check("retrig_latency", 64'(n), 64'd10);
    check("retrig_elapsed", 64'(elapsed), 64'd10);
    count_done(5, c);
    check("retrig_single_pulse", 64'(c), 64'd0);

    // Expiry coinciding with start: no done, re-armed.
    arm(32'd300, 32'd2, 1'b0);
    tick();
    duration = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    check("expstart_done", 64'(done), 64'd0);
    check("expstart_busy", 64'(busy), 64'd1);
    wait_done(20, n);
    check("expstart_latency", 64'(n), 64'd3);

    // Zero duration: done on the second edge after start.
    arm(32'd350, 32'd0, 1'b0);
    check("zero_busy", 64'(busy), 64'd1);
    check("zero_done_early", 64'(done), 64'd0);
    wait_done(5, n);
    check("zero_latency", 64'(n), 64'd1);
    check("zero_busy_after", 64'(busy), 64'd0);

    // Time base stepping backwards yields immediate expiry.
    arm(32'd1000, 32'd100, 1'b0);
    time_micro = 32'd10;
    tick();
    check("backwards_done", 64'(done), 64'd1);
    check("backwards_busy", 64'(busy), 64'd0);

    // Periodic request: 3 us from t=50.
    arm(32'd50, 32'd3, 1'b1);
    wait_done(10, n);
    check("per_first_latency", 64'(n), 64'd3);
`ifdef MICRO_DELAY_PERIODIC_EN
    check("per_busy_stays", 64'(busy), 64'd1);
    wait_done(10, n);
    check("per_second_latency", 64'(n), 64'd3);
    check("per_second_elapsed", 64'(elapsed), 64'd3);
    wait_done(10, n);
    check("per_third_latency", 64'(n), 64'd3);
    check("per_third_time", 64'(time_micro), 64'd60);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("per_abort_busy", 64'(busy), 64'd0);
`else
    check("per_ignored_busy", 64'(busy), 64'd0);
`endif
    count_done(10, c);
    check("per_no_more_done", 64'(c), 64'd0);

    // Reset mid-run at elapsed=2 of 8.
    arm(32'd400, 32'd8, 1'b0);
    tick(); tick();
    check("rst_pre_elapsed", 64'(elapsed), 64'd2);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_busy", 64'(busy), 64'd0);
    check("rst_async_done", 64'(done), 64'd0);
    check("rst_async_elapsed", 64'(elapsed), 64'd0);
    tick();
    rst = 1'b0;
    count_done(15, c);
    check("rst_no_done", 64'(c), 64'd0);
    check("rst_stays_idle", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
